// File: rtl/uart_transmit_state_machine_pkg.sv
// Shared definitions for the UART transmit path: frame-state encoding,
// data width, and the bit-ordering and parity helpers used at frame load.
package uart_transmit_state_machine_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } txState_t;

  // Reorder a character so that bit 0 is always the first bit on the line.
  // In 7-bit mode the top bit is forced to 0 so it never leaks into the frame.
  function automatic logic [DATA_W-1:0] orderBits(input logic [DATA_W-1:0] data,
                                                  input logic msbFirst,
                                                  input logic sevenBit);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < DATA_W - 1; i++) begin
      if (!msbFirst)     res[i] = data[i];
      else if (sevenBit) res[i] = data[DATA_W-2-i];
      else               res[i] = data[DATA_W-1-i];
    end
    if (sevenBit)      res[DATA_W-1] = 1'b0;
    else if (msbFirst) res[DATA_W-1] = data[0];
    else               res[DATA_W-1] = data[DATA_W-1];
    return res;
  endfunction

  // Parity over the transmitted bits only: even -> XOR, odd -> XNOR.
  function automatic logic parityOf(input logic [DATA_W-1:0] data,
                                    input logic sevenBit,
                                    input logic evenParity);
    logic [DATA_W-1:0] used;
    used = sevenBit ? {1'b0, data[DATA_W-2:0]} : data;
    return evenParity ? (^used) : (~^used);
  endfunction

endpackage

// File: rtl/uart_transmit_state_machine_bitclk_edge_detect.sv
// Turns the baud-rate clock into a one-MCLK bitTick on each rising edge,
// optionally behind a two-flop synchroniser when BITCLK is not MCLK-aligned.
module uart_transmit_state_machine_bitclk_edge_detect #(
  parameter int BITCLK_SYNC = 0
) (
  input  logic MCLK,
  input  logic reset_n,
  input  logic BITCLK,
  output logic bitTick
);

  logic bitClkS;
  logic bitClkPrev;

  generate
    if (BITCLK_SYNC != 0) begin : gSync
      logic [1:0] syncFf;
      // Two-flop synchroniser for an asynchronous BITCLK
      always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) syncFf <= '0;
        else          syncFf <= {syncFf[0], BITCLK};
      end
      assign bitClkS = syncFf[1];
    end else begin : gDirect
      assign bitClkS = BITCLK;
    end
  endgenerate

  // Previous BITCLK level for rising-edge detection
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) bitClkPrev <= 1'b0;
    else          bitClkPrev <= bitClkS;
  end

  assign bitTick = bitClkS & ~bitClkPrev;

endmodule

// File: rtl/uart_transmit_state_machine.sv
// eUSCI_A UART transmit engine: one-deep TXBUF feeding a shift register,
// framing start / 7-8 data / optional parity / 1-2 stop bits on each bitTick.
module uart_transmit_state_machine
  import uart_transmit_state_machine_pkg::*;
#(
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   BITCLK_SYNC = 0
) (
  input  logic              MCLK,
  input  logic              reset_n,
  input  logic              BITCLK,
  input  logic              wUCPEN,
  input  logic              wUCPAR,
  input  logic              wUCMSB,
  input  logic              wUC7BIT,
  input  logic              wUCSPB,
  input  logic              TxWrite,
  input  logic [DATA_W-1:0] TxData,
  output logic              Tx,
  output logic              TxBEN,
  output logic              rSetTxIFG,
  output logic              oSetTXCPTIFG,
  output logic              TxBusy
);

  txState_t          state;
  logic [DATA_W-1:0] txBuf;
  logic [DATA_W-1:0] shiftReg;
  logic              bufFull;
  logic [2:0]        bitCnt;
  logic              cfgPen;
  logic              cfgSpb;
  logic              cfg7Bit;
  logic              parBit;
  logic              bitTick;
  logic [2:0]        lastBit;
  logic              frameEnd;
  logic              loadFrame;

  uart_transmit_state_machine_bitclk_edge_detect #(
    .BITCLK_SYNC(BITCLK_SYNC)
  ) uEdge (
    .MCLK   (MCLK),
    .reset_n(reset_n),
    .BITCLK (BITCLK),
    .bitTick(bitTick)
  );

  assign lastBit   = cfg7Bit ? 3'd6 : 3'd7;
  // The tick that closes the final stop bit of the current frame
  assign frameEnd  = bitTick && ((state == STOP1 && !cfgSpb) || state == STOP2);
  // A waiting character starts on an idle tick or directly after the last stop bit
  assign loadFrame = bitTick && bufFull && (state == IDLE || frameEnd);
  assign TxBusy    = (state != IDLE);
  assign TxBEN     = TxBusy | bufFull;

  // Frame sequencer, TXBUF handling and registered line/interrupt outputs
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      Tx           <= IDLE_LEVEL;
      rSetTxIFG    <= 1'b0;
      oSetTXCPTIFG <= 1'b0;
      bufFull      <= 1'b0;
      txBuf        <= '0;
      shiftReg     <= '0;
      bitCnt       <= '0;
      cfgPen       <= 1'b0;
      cfgSpb       <= 1'b0;
      cfg7Bit      <= 1'b0;
      parBit       <= 1'b0;
    end else begin
      rSetTxIFG    <= 1'b0;
      oSetTXCPTIFG <= 1'b0;
      if (loadFrame) begin
        // Config is frozen here so mid-frame changes only affect the next frame
        state     <= START;
        Tx        <= 1'b0;
        shiftReg  <= orderBits(txBuf, wUCMSB, wUC7BIT);
        parBit    <= parityOf(txBuf, wUC7BIT, wUCPAR);
        cfgPen    <= wUCPEN;
        cfgSpb    <= wUCSPB;
        cfg7Bit   <= wUC7BIT;
        bufFull   <= 1'b0;
        rSetTxIFG <= 1'b1;
      end else if (frameEnd) begin
        state        <= IDLE;
        Tx           <= IDLE_LEVEL;
        oSetTXCPTIFG <= 1'b1;
      end else if (bitTick) begin
        case (state)
          START: begin
            state    <= DATA;
            Tx       <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[DATA_W-1:1]};
            bitCnt   <= 3'd0;
          end
          DATA: begin
            if (bitCnt == lastBit) begin
              if (cfgPen) begin
                state <= PARITY;
                Tx    <= parBit;
              end else begin
                state <= STOP1;
                Tx    <= 1'b1;
              end
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              Tx       <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[DATA_W-1:1]};
            end
          end
          PARITY: begin
            state <= STOP1;
            Tx    <= 1'b1;
          end
          STOP1: begin
            state <= STOP2;
            Tx    <= 1'b1;
          end
          default: ;
        endcase
      end
      // A CPU write always wins the buffer, even on the transfer cycle
      if (TxWrite) begin
        txBuf   <= TxData;
        bufFull <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmit_state_machine.sv
// Scoreboard bench for the UART transmitter: expected frames are queued when
// a character is written and compared against mid-bit samples of Tx.
module tb_uart_transmit_state_machine;

  localparam int HALF_BIT = 80;
  localparam int BIT_CYC  = 16;

  logic       MCLK    = 1'b0;
  logic       reset_n = 1'b0;
  logic       BITCLK  = 1'b0;
  logic       wUCPEN  = 1'b0;
  logic       wUCPAR  = 1'b0;
  logic       wUCMSB  = 1'b0;
  logic       wUC7BIT = 1'b0;
  logic       wUCSPB  = 1'b0;
  logic       TxWrite = 1'b0;
  logic [7:0] TxData  = 8'h00;
  logic       Tx;
  logic       TxBEN;
  logic       rSetTxIFG;
  logic       oSetTXCPTIFG;
  logic       TxBusy;

  typedef struct {
    logic [11:0] bits;
    int          len;
    bit          b2b;
    string       tag;
  } frame_t;

  frame_t expQ[$];
  frame_t cur;
  logic [11:0] got;
  int bitPos    = 0;
  bit inFrame   = 1'b0;
  bit monEnable = 1'b1;
  int sampleIdx = 0;
  int lastEnd   = -100;

  int checks  = 0;
  int errors  = 0;
  int rSetCnt = 0;
  int cptCnt  = 0;
  int busyCnt = 0;
  int r0, c0, b0;

  uart_transmit_state_machine #(
    .IDLE_LEVEL (1'b1),
    .BITCLK_SYNC(0)
  ) dut (
    .MCLK        (MCLK),
    .reset_n     (reset_n),
    .BITCLK      (BITCLK),
    .wUCPEN      (wUCPEN),
    .wUCPAR      (wUCPAR),
    .wUCMSB      (wUCMSB),
    .wUC7BIT     (wUC7BIT),
    .wUCSPB      (wUCSPB),
    .TxWrite     (TxWrite),
    .TxData      (TxData),
    .Tx          (Tx),
    .TxBEN       (TxBEN),
    .rSetTxIFG   (rSetTxIFG),
    .oSetTXCPTIFG(oSetTXCPTIFG),
    .TxBusy      (TxBusy)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #2;
    forever #HALF_BIT BITCLK = ~BITCLK;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic frame_t buildFrame(input logic [7:0] d, input bit pen, input bit par,
                                        input bit msb, input bit b7, input bit spb,
                                        input bit b2b, input string tag);
    frame_t f;
    int n;
    int k;
    logic p;
    logic b;
    n = b7 ? 7 : 8;
    f.bits = '0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = d[msb ? (n - 1 - i) : i];
      f.bits[k] = b;
      p = p ^ b;
      k++;
    end
    if (pen) begin
      f.bits[k] = par ? p : ~p;
      k++;
    end
    f.bits[k] = 1'b1;
    k++;
    if (spb) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.len = k;
    f.b2b = b2b;
    f.tag = tag;
    return f;
  endfunction

  // Pulse and busy-time accounting, sampled on the inactive edge
  always @(negedge MCLK) begin
    if (rSetTxIFG)    rSetCnt++;
    if (oSetTXCPTIFG) cptCnt++;
    if (TxBusy)       busyCnt++;
  end

  // Mid-bit line monitor feeding the scoreboard
  always begin
    @(posedge BITCLK);
    #HALF_BIT;
    sampleIdx++;
    if (!monEnable) begin
      inFrame = 1'b0;
    end else if (!inFrame) begin
      if (Tx === 1'b0) begin
        checkVal("frame_expected", (expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          cur = expQ.pop_front();
          if (cur.b2b) checkVal({cur.tag, "_gap"}, sampleIdx - lastEnd, 1);
          got     = '0;
          bitPos  = 1;
          inFrame = 1'b1;
        end
      end
    end else begin
      got[bitPos] = Tx;
      bitPos++;
      if (bitPos == cur.len) begin
        checkVal(cur.tag, got, cur.bits);
        lastEnd = sampleIdx;
        inFrame = 1'b0;
      end
    end
  end

  task automatic setCfg(input bit pen, input bit par, input bit msb, input bit b7, input bit spb);
    wUCPEN  = pen;
    wUCPAR  = par;
    wUCMSB  = msb;
    wUC7BIT = b7;
    wUCSPB  = spb;
  endtask

  task automatic writeByte(input logic [7:0] d);
    @(negedge MCLK);
    TxData  = d;
    TxWrite = 1'b1;
    @(negedge MCLK);
    TxWrite = 1'b0;
  endtask

  task automatic syncAfterTick();
    @(posedge BITCLK);
    repeat (3) @(negedge MCLK);
  endtask

  task automatic snap();
    r0 = rSetCnt;
    c0 = cptCnt;
    b0 = busyCnt;
  endtask

  task automatic waitBusy(input string tag);
    int n = 0;
    while (TxBusy !== 1'b1 && n < 100) begin
      @(negedge MCLK);
      n++;
    end
    checkVal({tag, "_busy"}, TxBusy, 1);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (!(expQ.size() == 0 && !inFrame && TxBEN == 1'b0) && n < 2000) begin
      @(negedge MCLK);
      n++;
    end
    checkVal({tag, "_done"}, (n < 2000), 1);
    repeat (20) @(negedge MCLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge MCLK);
    checkVal("rst_Tx", Tx, 1);
    checkVal("rst_TxBEN", TxBEN, 0);
    checkVal("rst_TxBusy", TxBusy, 0);
    checkVal("rst_rSetTxIFG", rSetTxIFG, 0);
    checkVal("rst_TXCPTIFG", oSetTXCPTIFG, 0);
    reset_n = 1'b1;
    repeat (3 * BIT_CYC) @(negedge MCLK);
    checkVal("idle_TxBEN", TxBEN, 0);
    checkVal("idle_rSet", rSetCnt, 0);

    // 8N1 LSB-first 0xA5, start on the first tick after the write
    setCfg(0, 0, 0, 0, 0);
    snap();
    expQ.push_back(buildFrame(8'hA5, 0, 0, 0, 0, 0, 0, "t1_frame"));
    syncAfterTick();
    writeByte(8'hA5);
    checkVal("t1_TxBEN", TxBEN, 1);
    checkVal("t1_pre_busy", TxBusy, 0);
    @(posedge BITCLK);
    @(posedge MCLK);
    #1;
    checkVal("t1_start_busy", TxBusy, 1);
    checkVal("t1_start_Tx", Tx, 0);
    checkVal("t1_start_rSet", rSetTxIFG, 1);
    waitDone("t1");
    checkVal("t1_rSet", rSetCnt - r0, 1);
    checkVal("t1_cpt", cptCnt - c0, 1);
    checkVal("t1_bits", busyCnt - b0, 10 * BIT_CYC);

    // 8O2 LSB-first 0x55
    setCfg(1, 0, 0, 0, 1);
    snap();
    expQ.push_back(buildFrame(8'h55, 1, 0, 0, 0, 1, 0, "t2_frame"));
    syncAfterTick();
    writeByte(8'h55);
    waitDone("t2");
    checkVal("t2_rSet", rSetCnt - r0, 1);
    checkVal("t2_cpt", cptCnt - c0, 1);
    checkVal("t2_bits", busyCnt - b0, 12 * BIT_CYC);

    // 8E1 MSB-first 0x34, then a second write mid-DATA with new config
    setCfg(1, 1, 1, 0, 0);
    snap();
    expQ.push_back(buildFrame(8'h34, 1, 1, 1, 0, 0, 0, "t3_frame1"));
    syncAfterTick();
    writeByte(8'h34);
    waitBusy("t3");
    repeat (3 * BIT_CYC) @(negedge MCLK);
    setCfg(0, 0, 0, 0, 0);
    expQ.push_back(buildFrame(8'hC3, 0, 0, 0, 0, 0, 1, "t3_frame2"));
    writeByte(8'hC3);
    waitDone("t3");
    checkVal("t3_rSet", rSetCnt - r0, 2);
    checkVal("t3_cpt", cptCnt - c0, 1);
    checkVal("t3_bits", busyCnt - b0, 21 * BIT_CYC);

    // 7O2 MSB-first 0xB5: bit 7 must be dropped
    setCfg(1, 0, 1, 1, 1);
    snap();
    expQ.push_back(buildFrame(8'hB5, 1, 0, 1, 1, 1, 0, "t4_frame"));
    syncAfterTick();
    writeByte(8'hB5);
    waitDone("t4");
    checkVal("t4_cpt", cptCnt - c0, 1);
    checkVal("t4_bits", busyCnt - b0, 11 * BIT_CYC);

    // Two writes before START: last one wins
    setCfg(0, 0, 0, 0, 0);
    snap();
    expQ.push_back(buildFrame(8'h22, 0, 0, 0, 0, 0, 0, "t5a_frame"));
    syncAfterTick();
    writeByte(8'h11);
    writeByte(8'h22);
    waitDone("t5a");
    checkVal("t5a_rSet", rSetCnt - r0, 1);
    checkVal("t5a_cpt", cptCnt - c0, 1);

    // Write coincident with the buffer->shift transfer
    snap();
    expQ.push_back(buildFrame(8'h3C, 0, 0, 0, 0, 0, 0, "t5b_frame1"));
    expQ.push_back(buildFrame(8'h96, 0, 0, 0, 0, 0, 1, "t5b_frame2"));
    syncAfterTick();
    writeByte(8'h3C);
    @(posedge BITCLK);
    TxData  = 8'h96;
    TxWrite = 1'b1;
    @(posedge MCLK);
    #1;
    TxWrite = 1'b0;
    checkVal("t5b_rSet_pulse", rSetTxIFG, 1);
    checkVal("t5b_start_Tx", Tx, 0);
    waitDone("t5b");
    checkVal("t5b_rSet", rSetCnt - r0, 2);
    checkVal("t5b_cpt", cptCnt - c0, 1);
    checkVal("t5b_bits", busyCnt - b0, 20 * BIT_CYC);

    // Reset in the middle of DATA with a character waiting in TXBUF
    monEnable = 1'b0;
    syncAfterTick();
    writeByte(8'h00);
    waitBusy("t6");
    repeat (BIT_CYC + BIT_CYC / 2) @(negedge MCLK);
    writeByte(8'hFF);
    checkVal("t6_pre_Tx", Tx, 0);
    checkVal("t6_pre_TxBEN", TxBEN, 1);
    @(negedge MCLK);
    #1;
    reset_n = 1'b0;
    #1;
    checkVal("t6_rst_Tx", Tx, 1);
    checkVal("t6_rst_TxBEN", TxBEN, 0);
    checkVal("t6_rst_TxBusy", TxBusy, 0);
    repeat (2) @(negedge MCLK);
    reset_n = 1'b1;
    snap();
    repeat (5 * BIT_CYC) @(negedge MCLK);
    checkVal("t6_post_TxBEN", TxBEN, 0);
    checkVal("t6_post_Tx", Tx, 1);
    checkVal("t6_post_rSet", rSetCnt - r0, 0);
    monEnable = 1'b1;
    repeat (2 * BIT_CYC) @(negedge MCLK);
    expQ.push_back(buildFrame(8'h5A, 0, 0, 0, 0, 0, 0, "t6_frame"));
    syncAfterTick();
    writeByte(8'h5A);
    waitDone("t6");
    checkVal("t6_cpt", cptCnt - r0 + r0 - c0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
